// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame states and parity helper for the tx/rx pair.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} tx_state_t;
   // Narrower words are zero-extended by the caller; zeros leave the XOR unchanged.
   function automatic logic calc_parity(input logic [8:0] data, input logic odd);
      return ^data ^ odd;
   endfunction
endpackage

// File: rtl/uart_baud_tick_detect.sv
// baud_tick_detect: one-clk pulse on each rising edge of an already-registered baud square wave.
module baud_tick_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic baud_i,
   output logic tick_o
);
   logic r_baud_prev;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_baud_prev <= 1'b0;
      else r_baud_prev <= baud_i;
   assign tick_o = baud_i & ~r_baud_prev;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, LSB-first start/data/parity/stop frame out, paced by baud ticks.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 baudClk_i,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
   tx_state_t r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0] r_bit_cnt;
   logic r_stop_cnt, r_parity, w_tick;
   baud_tick_detect u_tick (.clk_i(clk_i), .rst_i(rst_i), .baud_i(baudClk_i), .tick_o(w_tick));
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_parity   <= 1'b0;
         tx_o       <= 1'b1;
         ready_o    <= 1'b1;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (r_state)
            // An accept wins over a coincident tick, so the start bit waits for the next one.
            IDLE: if (valid_i && ready_o) begin
               r_shift  <= data_i;
               r_parity <= calc_parity(9'(data_i), PARITY_ODD != 0);
               ready_o  <= 1'b0;
               busy_o   <= 1'b1;
               r_state  <= LOAD;
            end
            LOAD: if (w_tick) begin
               tx_o    <= 1'b0;
               r_state <= START;
            end
            START: if (w_tick) begin
               tx_o      <= r_shift[0];
               r_bit_cnt <= '0;
               r_state   <= DATA;
            end
            DATA: if (w_tick) begin
               if (r_bit_cnt == LAST) begin
                  if (PARITY_EN != 0) begin
                     tx_o    <= r_parity;
                     r_state <= PARITY;
                  end else begin
                     tx_o       <= 1'b1;
                     r_stop_cnt <= 1'b0;
                     r_state    <= STOP;
                  end
               end else begin
                  r_shift   <= r_shift >> 1;
                  tx_o      <= r_shift[1];
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            PARITY: if (w_tick) begin
               tx_o       <= 1'b1;
               r_stop_cnt <= 1'b0;
               r_state    <= STOP;
            end
            STOP: if (w_tick) begin
               if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                  done_o  <= 1'b1;
                  ready_o <= 1'b1;
                  busy_o  <= 1'b0;
                  r_state <= IDLE;
               end else r_stop_cnt <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) each with its own driver, scoreboard queue and line monitor.
module tb_uart_tx;
   localparam int P = 20;
   typedef struct {
      logic [11:0] bits;
      int n;
      int acc;
   } frame_t;
   logic clk, baud;
   int cyc = 0, bcnt = 0, checks = 0, errors = 0;
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      baud = 0;
      forever begin
         @(negedge clk);
         bcnt = (bcnt + 1) % P;
         baud = bcnt < P / 2;
      end
   end
   task automatic chk(input bit ok, input string name, input int g, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s inst%0d got %0h expected %0h at cycle %0d", name, g, act, req, cyc);
      end
   endtask
   // Expected line levels, one entry per bit period, built from the frame rules.
   function automatic frame_t model(input int pe, input int po, input int sb, input logic [7:0] d, input int acc);
      frame_t f;
      int k = 0;
      f.bits = '1;
      f.acc = acc;
      f.bits[k] = 1'b0;
      k++;
      for (int i = 0; i < 8; i++) begin
         f.bits[k] = d[i];
         k++;
      end
      if (pe != 0) begin
         f.bits[k] = ((($countones(d) + po) % 2) == 1);
         k++;
      end
      f.n = k + sb;
      return f;
   endfunction
   for (genvar g = 0; g < 4; g++) begin : inst
      localparam int PE = (g == 1 || g == 2) ? 1 : 0;
      localparam int PO = (g == 2) ? 1 : 0;
      localparam int SB = (g == 3) ? 2 : 1;
      localparam int NB = 9 + PE + SB;
      logic rst, valid, ready, tx, busy, done;
      logic [7:0] data;
      logic mon = 0, fin = 0;
      int sent = 0, got = 0, last_start = 0, prev_start = 0, last_lat = 0;
      frame_t q[$];
      uart_tx #(.DATA_BITS(8), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)) dut (
         .clk_i(clk), .rst_i(rst), .baudClk_i(baud), .data_i(data), .valid_i(valid),
         .ready_o(ready), .tx_o(tx), .busy_o(busy), .done_o(done)
      );
      task automatic send(input logic [7:0] d);
         int w = 0;
         valid = 1;
         data = d;
         while (!ready && w < 3000) begin
            @(negedge clk);
            w++;
         end
         chk(ready === 1'b1, "ready_wait", g, w, 3000);
         q.push_back(model(PE, PO, SB, d, cyc + 1));
         sent++;
         @(negedge clk);
         valid = 0;
      endtask
      task automatic wait_idle();
         int w = 0;
         while ((q.size() != 0 || mon || busy) && w < 5000) begin
            @(negedge clk);
            w++;
         end
         chk(w < 5000, "idle_wait", g, w, 5000);
      endtask
      initial begin
         int w, dn;
         rst = 1;
         valid = 0;
         data = 0;
         repeat (3) @(negedge clk);
         chk({tx, ready, busy, done} === 4'b1100, "reset_state", g, {tx, ready, busy, done}, 4'b1100);
         rst = 0;
         send(8'h55);
         send(8'hA3);
         send(8'h00);
         wait_idle();
         repeat (12) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            send(8'($urandom));
         end
         wait_idle();
         send(8'h00);
         send(8'hFF);
         wait_idle();
         chk(last_start - prev_start == (NB + 1) * P, "b2b_gap", g, last_start - prev_start, (NB + 1) * P);
         send(8'h33);
         repeat (3 * P) @(negedge clk);
         valid = 1;
         data = 8'hAA;
         repeat (2) @(negedge clk);
         valid = 0;
         wait_idle();
         repeat ((NB + 2) * P) @(negedge clk);
         chk(got == sent, "busy_ignore_count", g, got, sent);
         @(posedge baud);
         send(8'hC6);
         wait_idle();
         chk(last_lat == P, "tick_accept_defer", g, last_lat, P);
         send(8'h0F);
         w = 0;
         while (!mon && w < 2000) begin
            @(negedge clk);
            w++;
         end
         repeat (4 * P + P / 2) @(negedge clk);
         #3 rst = 1;
         #1 chk({tx, ready, busy, done} === 4'b1100, "async_reset", g, {tx, ready, busy, done}, 4'b1100);
         repeat (2) @(negedge clk);
         rst = 0;
         dn = 0;
         repeat ((NB + 2) * P) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
         end
         chk(dn == 0, "no_done_after_reset", g, dn, 0);
         send(8'h81);
         wait_idle();
         chk(got == sent, "frame_count", g, got, sent);
         fin = 1;
      end
      initial begin
         frame_t f;
         logic [11:0] bad;
         bit ctl, ab;
         forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
               mon = 1;
               if (q.size() == 0) begin
                  chk(0, "unexpected_frame", g, 1, 0);
                  while (busy && !rst) @(negedge clk);
               end else begin
                  f = q.pop_front();
                  got++;
                  prev_start = last_start;
                  last_start = cyc;
                  last_lat = cyc - f.acc;
                  chk(last_lat >= 1 && last_lat <= P, "accept_latency", g, last_lat, P);
                  bad = '0;
                  ctl = 0;
                  ab = 0;
                  for (int s = 0; s < f.n * P; s++) begin
                     if (s > 0) @(negedge clk);
                     if (rst) begin
                        ab = 1;
                        break;
                     end
                     if (tx !== f.bits[s / P]) bad[s / P] = 1'b1;
                     if (done !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) ctl = 1;
                  end
                  if (ab) while (rst) @(negedge clk);
                  else begin
                     for (int b = 0; b < f.n; b++)
                        chk(!bad[b], $sformatf("frame%0d_bit%0d", got, b), g, bad[b] ? !f.bits[b] : f.bits[b], f.bits[b]);
                     chk(!ctl, "in_frame_flags", g, ctl, 0);
                     @(negedge clk);
                     chk({done, ready, busy, tx} === 4'b1101, "frame_end", g, {done, ready, busy, tx}, 4'b1101);
                     @(negedge clk);
                     chk(done === 1'b0, "done_width", g, done, 0);
                  end
               end
               mon = 0;
            end
         end
      end
   end
   initial begin
      int c = 0;
      while (!(inst[0].fin && inst[1].fin && inst[2].fin && inst[3].fin) && c < 60000) begin
         @(negedge clk);
         c++;
      end
      chk(c < 60000, "global_timeout", 0, c, 60000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
